// File: rtl/alu_issue_stage.sv
// ALU issue stage: selects forwarded or register-file operands and holds them in a
// single-entry valid/ready pipeline register feeding the ALU.
module alu_issue_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_aluop,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [4:0]         in_rd,
    input  logic [31:0]        in_rs1_val,
    input  logic [31:0]        in_rs2_val,
    input  logic [31:0]        in_imm,
    input  logic               in_use_imm,
    input  logic               ex_fwd_valid,
    input  logic [4:0]         ex_fwd_rd,
    input  logic [31:0]        ex_fwd_data,
    input  logic               wb_fwd_valid,
    input  logic [4:0]         wb_fwd_rd,
    input  logic [31:0]        wb_fwd_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] A,
    output logic signed [31:0] B,
    output logic [4:0]         ALUOp,
    output logic [4:0]         out_rd,
    output logic               out_illegal
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;

    logic        accept;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] rs2Fwd;
    logic        illegal;

    // EX result is newer than WB, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [31:0] forwardOperand(input logic [4:0] rs, input logic [31:0] rfVal,
                                                   input logic exV, input logic [4:0] exRd,
                                                   input logic [31:0] exData,
                                                   input logic wbV, input logic [4:0] wbRd,
                                                   input logic [31:0] wbData);
        logic [31:0] r;
        r = rfVal;
        if (FWD_EN && rs != 5'd0) begin
            if (exV && exRd == rs)
                r = exData;
            else if (wbV && wbRd == rs)
                r = wbData;
        end
        return r;
    endfunction

    always_comb begin
        in_ready = (!out_valid || out_ready) && !rst;
        accept   = in_valid && in_ready;
        opA      = forwardOperand(in_rs1, in_rs1_val, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                                  wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        rs2Fwd   = forwardOperand(in_rs2, in_rs2_val, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                                  wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        opB      = in_use_imm ? in_imm : rs2Fwd;
        illegal  = (in_aluop != OP_ADD) && (in_aluop != OP_SUB);
    end

    // Flush beats a same-cycle accept and leaves the payload registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            A           <= '0;
            B           <= '0;
            ALUOp       <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            A           <= opA;
            B           <= opB;
            ALUOp       <= in_aluop;
            out_rd      <= in_rd;
            out_illegal <= illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: forwarding, immediate select, stall,
// flush and reset behaviour with hand-computed expectations.
module tb_alu_issue_stage;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_aluop;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [4:0]         in_rd;
    logic [31:0]        in_rs1_val;
    logic [31:0]        in_rs2_val;
    logic [31:0]        in_imm;
    logic               in_use_imm;
    logic               ex_fwd_valid;
    logic [4:0]         ex_fwd_rd;
    logic [31:0]        ex_fwd_data;
    logic               wb_fwd_valid;
    logic [4:0]         wb_fwd_rd;
    logic [31:0]        wb_fwd_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] A;
    logic signed [31:0] B;
    logic [4:0]         ALUOp;
    logic [4:0]         out_rd;
    logic               out_illegal;

    int compared   = 0;
    int mismatched = 0;

    alu_issue_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd),
        .ex_fwd_data(ex_fwd_data), .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
        .wb_fwd_data(wb_fwd_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .A(A), .B(B), .ALUOp(ALUOp), .out_rd(out_rd),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] imm, input logic useImm);
        in_valid   = v;
        in_aluop   = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_rs1_val = v1;
        in_rs2_val = v2;
        in_imm     = imm;
        in_use_imm = useImm;
    endtask

    task automatic setForward(input logic exV, input logic [4:0] exRd, input logic [31:0] exD,
                              input logic wbV, input logic [4:0] wbRd, input logic [31:0] wbD);
        ex_fwd_valid = exV;
        ex_fwd_rd    = exRd;
        ex_fwd_data  = exD;
        wb_fwd_valid = wbV;
        wb_fwd_rd    = wbRd;
        wb_fwd_data  = wbD;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        setForward(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step();
        step();
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_A", A, 0);
        checkOutput("rst_B", B, 0);
        checkOutput("rst_op", ALUOp, 0);
        checkOutput("rst_rd", out_rd, 0);
        checkOutput("rst_ill", out_illegal, 0);
        checkOutput("rst_inready", in_ready, 0);

        rst = 1'b0;
        #1;
        checkOutput("idle_inready", in_ready, 1);

        // ADD, no hazards
        applyStimulus(1'b1, 5'b00011, 5'd1, 5'd2, 5'd4, 32'd5, 32'hFFFF_FFFD, 32'd0, 1'b0);
        step();
        checkOutput("add_valid", out_valid, 1);
        checkOutput("add_A", A, 32'd5);
        checkOutput("add_B", B, 32'hFFFF_FFFD);
        checkOutput("add_op", ALUOp, 5'b00011);
        checkOutput("add_ill", out_illegal, 0);
        checkOutput("add_rd", out_rd, 5'd4);

        // Double hazard: EX beats WB
        applyStimulus(1'b1, 5'b00100, 5'd7, 5'd7, 5'd3, 32'h99, 32'h98, 32'd0, 1'b0);
        setForward(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        step();
        checkOutput("hz_ex_A", A, 32'h11);
        checkOutput("hz_ex_B", B, 32'h11);
        setForward(1'b0, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        step();
        checkOutput("hz_wb_A", A, 32'h22);
        checkOutput("hz_wb_B", B, 32'h22);
        applyStimulus(1'b1, 5'b00011, 5'd0, 5'd5, 5'd3, 32'h55, 32'h66, 32'd0, 1'b0);
        setForward(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        step();
        checkOutput("hz_x0_A", A, 32'h55);
        checkOutput("hz_nomatch_B", B, 32'h66);

        // Immediate overrides an rs2 forwarding match
        applyStimulus(1'b1, 5'b00011, 5'd1, 5'd7, 5'd3, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1);
        setForward(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0);
        step();
        checkOutput("imm_B", B, 32'hFFFF_FFF0);
        checkOutput("imm_A", A, 32'h1);
        setForward(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Illegal opcode still issues
        applyStimulus(1'b1, 5'b00111, 5'd1, 5'd2, 5'd9, 32'h3, 32'h4, 32'd0, 1'b0);
        step();
        checkOutput("ill_flag", out_illegal, 1);
        checkOutput("ill_op", ALUOp, 5'b00111);
        checkOutput("ill_valid", out_valid, 1);

        // Stall for three cycles, then release loads the waiting instruction
        applyStimulus(1'b1, 5'b00011, 5'd1, 5'd2, 5'd10, 32'hAAAA, 32'h1, 32'd0, 1'b0);
        step();
        applyStimulus(1'b1, 5'b00100, 5'd1, 5'd2, 5'd11, 32'hBBBB, 32'h2, 32'd0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_inready", in_ready, 0);
            step();
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_A", A, 32'hAAAA);
            checkOutput("stall_rd", out_rd, 5'd10);
            checkOutput("stall_op", ALUOp, 5'b00011);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_inready", in_ready, 1);
        step();
        checkOutput("release_A", A, 32'hBBBB);
        checkOutput("release_rd", out_rd, 5'd11);
        checkOutput("release_valid", out_valid, 1);

        // Drain with no new instruction
        in_valid = 1'b0;
        step();
        checkOutput("drain_valid", out_valid, 0);
        checkOutput("drain_A_hold", A, 32'hBBBB);

        // Flush beats a simultaneous accept
        applyStimulus(1'b1, 5'b00011, 5'd1, 5'd2, 5'd12, 32'hCCCC, 32'h3, 32'd0, 1'b0);
        flush = 1'b1;
        step();
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_A_hold", A, 32'hBBBB);
        flush = 1'b0;

        // Flush drops a held, stalled instruction
        step();
        checkOutput("reload_valid", out_valid, 1);
        checkOutput("reload_A", A, 32'hCCCC);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        checkOutput("flush_held_valid", out_valid, 0);
        flush = 1'b0;

        // Reset during a stall clears everything; accept right after release
        applyStimulus(1'b1, 5'b00111, 5'd1, 5'd2, 5'd13, 32'hDDDD, 32'h4, 32'd0, 1'b0);
        step();
        checkOutput("pre_rst_valid", out_valid, 1);
        step();
        rst = 1'b1;
        step();
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_A", A, 0);
        checkOutput("midrst_B", B, 0);
        checkOutput("midrst_op", ALUOp, 0);
        checkOutput("midrst_rd", out_rd, 0);
        checkOutput("midrst_ill", out_illegal, 0);
        rst = 1'b0;
        applyStimulus(1'b1, 5'b00011, 5'd1, 5'd2, 5'd14, 32'hEEEE, 32'h5, 32'd0, 1'b0);
        #1;
        checkOutput("postrst_inready", in_ready, 1);
        step();
        checkOutput("postrst_valid", out_valid, 1);
        checkOutput("postrst_A", A, 32'hEEEE);
        checkOutput("postrst_rd", out_rd, 5'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
